conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Sliding-window generator at the front of the convolution datapath. It sits on the other side of the packed window bus that the conv engine consumes.
- Accepts a raster-order pixel stream, one word per transfer, and keeps R-1 line buffers plus an R x C window register.
- Presents each complete R x C neighbourhood as one flattened bus, in the same word order the conv engine indexes with its address counter.
- Uses a valid/ready handshake on both sides so a slow multi-cycle conv engine can stall the stream.

Parameters:
In_d_W, 32, pixel word width in bits
R, 3, window rows
C, 3, window columns
IMG_W, 8, image width in pixels (must be >= C)
IMG_H, 8, image height in pixels (must be >= R)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
clr  input  1  synchronous frame restart; clears position counters and flags only
pix_in  input  In_d_W  input pixel word
pix_valid  input  1  pix_in is valid
pix_ready  output  1  block can accept a pixel this cycle
win  output  R*C*In_d_W  flattened window; word k = r*C + c occupies bits [k*In_d_W +: In_d_W]; r=0 is the oldest (top) row, c=0 is the oldest (left) column
win_valid  output  1  win holds a complete window
win_ready  input  1  consumer accepts win this cycle
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Accept: a pixel is accepted when pix_valid && pix_ready.
- pix_ready = !(win_valid && !win_ready). This is combinational, and it is the only combinational path.
- Position counters: x counts 0..IMG_W-1 and y counts 0..IMG_H-1. Both advance only on accept. When x reaches IMG_W-1, x wraps to 0 and y increments. After (IMG_W-1, IMG_H-1), both wrap to 0 and the next frame starts.
- Line buffers: lb[0..R-2], each IMG_W words. On accept at column x: lb[0][x] <= pix_in and lb[i][x] <= lb[i-1][x].
- Window shift register: on accept, every row shifts one column left (c decreases). The new column c=C-1 is loaded bottom to top:
  - r=R-1 gets pix_in
  - r=R-2 gets the old lb[0][x]
  - ... r=0 gets the old lb[R-2][x]
- win is the window shift register itself.
- Window valid condition: the accepted pixel has y >= R-1 and x >= C-1. On the next cycle win_valid = 1, so latency is 1 clock from the accepting edge to win_valid.
- Window count: there are no padded windows, so (IMG_W-C+1)*(IMG_H-R+1) windows per frame.
- win_valid clearing: win_valid falls on a win_ready handshake, unless a new window is produced in the same cycle.
- Back-to-back windows: a pixel accepted in the same cycle as win_ready (pix_ready = 1) that forms a valid window keeps win_valid = 1 with the new window. This sustains 1 window per clock.
- Stall stability: while win_valid=1 and win_ready=0, pix_ready=0, so no pixel is accepted and win, the line buffers and the counters hold stable.
- Do not sample win when win_valid = 0. Content outside valid positions, for example stale columns across a row wrap, is unspecified.
- frame_done: pulses 1 clock after acceptance of pixel (IMG_W-1, IMG_H-1), coincident with that frame's last win_valid.
- Reset (rst=1): x=y=0, win_valid=0, frame_done=0, win=0, line buffers need not be cleared. pix_ready=1 one cycle after reset. Reset mid-frame discards the partial frame.
- clr=1: x=y=0, win_valid=0, frame_done=0, and no accept occurs that cycle (clr has priority over the handshake). Line buffer and window contents are left as is.
- rst has priority over clr.

Test Plan:
- IMG_W=IMG_H=4, R=C=3, pix_valid=1 and win_ready=1 continuously, pixels 0..15:
  - exactly 4 win_valid pulses, one cycle after pixels 10, 11, 14 and 15;
  - first win words k0..k8 = 0,1,2,4,5,6,8,9,10;
  - last win = 5,6,7,9,10,11,13,14,15;
  - frame_done high in the same cycle as the 4th window.
- Backpressure: same stream with win_ready=0 for 5 cycles after the first win_valid:
  - pix_ready=0 and win holds 0,1,2,4,5,6,8,9,10 for all 5 cycles;
  - no pixel is lost, and the remaining windows match the previous test.
- Input gaps: pix_valid toggles 1/0 every cycle -> window contents identical to the first test, each win_valid one cycle after its accepting edge.
- Two frames back to back, pixels 0..15 then 100..115:
  - second frame's first window = 100,101,102,104,105,106,108,109,110;
  - no window is produced from frame-boundary mixes, e.g. pixels 12..15 with 100..103.
- rst asserted after pixel 9, then pixels 0..15 -> first window after restart = 0,1,2,4,5,6,8,9,10; win_valid=0 during and after reset until then.
- clr with pix_valid=1 on the same cycle -> that pixel is not accepted; the next accepted pixel is position (0,0).

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: sliding R x C window generator for a raster pixel stream.
// Keeps R-1 line buffers and an R x C window shift register, and presents each
// complete neighbourhood on a flattened bus with a valid/ready handshake.
module conv_window_gen #(
  parameter int In_d_W = 32,
  parameter int R      = 3,
  parameter int C      = 3,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [In_d_W-1:0]       pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [R*C*In_d_W-1:0]   win,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic                    frame_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_WIN  = XW'(C - 1);
  localparam logic [YW-1:0] Y_WIN  = YW'(R - 1);

  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   win_valid_q, win_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic [R*C*In_d_W-1:0]  win_q, win_d;
  logic [In_d_W-1:0]      lb_q [R-1][IMG_W];
  logic [In_d_W-1:0]      lb_d [R-1][IMG_W];
  logic                   accept;

  // Stall the stream only while a window is waiting on the consumer.
  assign pix_ready  = !(win_valid_q && !win_ready);
  assign accept     = pix_valid && pix_ready && !clr && !rst;
  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

  // Raster position counters; clr restarts the frame and blocks the accept.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Window-valid flag and end-of-frame pulse; a new window overrides a consume.
  always_comb begin
    win_valid_d  = win_valid_q;
    frame_done_d = accept && (x_q == X_LAST) && (y_q == Y_LAST);
    if (clr) begin
      win_valid_d = 1'b0;
    end else if (accept && (y_q >= Y_WIN) && (x_q >= X_WIN)) begin
      win_valid_d = 1'b1;
    end else if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // Window shift: rows move one column left, new right column comes from the
  // line buffers (older rows on top) with the incoming pixel at the bottom.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C - 1; c++) begin
          win_d[(r*C + c)*In_d_W +: In_d_W] = win_q[(r*C + c + 1)*In_d_W +: In_d_W];
        end
      end
      for (int r = 0; r < R - 1; r++) begin
        win_d[(r*C + C - 1)*In_d_W +: In_d_W] = lb_q[R-2-r][x_q];
      end
      win_d[((R-1)*C + C - 1)*In_d_W +: In_d_W] = pix_in;
    end
  end

  // Line buffers cascade at the current column: lb[0] takes the new pixel.
  always_comb begin
    lb_d = lb_q;
    if (accept) begin
      lb_d[0][x_q] = pix_in;
      for (int i = 1; i < R - 1; i++) begin
        lb_d[i][x_q] = lb_q[i-1][x_q];
      end
    end
  end

  // Control and window registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffer storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with a 4x4 image and 3x3 window.
module tb_conv_window_gen;

  localparam int W  = 32;
  localparam int NB = 9 * W;

  logic          clk = 1'b0;
  logic          rst, clr, pix_valid, win_ready;
  logic [W-1:0]  pix_in;
  logic          pix_ready, win_valid, frame_done;
  logic [NB-1:0] win;

  int total = 0;
  int bad   = 0;

  // Hand-computed windows for pixels 0..15 (word k = r*3 + c).
  int tbl [4][9] = '{'{0,1,2,4,5,6,8,9,10},
                     '{1,2,3,5,6,7,9,10,11},
                     '{4,5,6,8,9,10,12,13,14},
                     '{5,6,7,9,10,11,13,14,15}};
  int win_idx [4] = '{10, 11, 14, 15};

  always #5 clk = ~clk;

  conv_window_gen #(.In_d_W(W), .R(3), .C(3), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win(win), .win_valid(win_valid), .win_ready(win_ready),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_win(input int base, input int n);
    logic [NB-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*W +: W] = W'(base + tbl[n][k]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    pix_valid = 1'b0;
    win_ready = 1'b1;
    tick();
    chk("idle_wv", win_valid, 0);
    chk("idle_fd", frame_done, 0);
  endtask

  // Stream npix pixels base+0.. and check every window as it is produced.
  task automatic run_frame(input int base, input bit gaps, input int stall_n, input int npix);
    int  idx, nwin, cyc, stall_left;
    bit  acc;
    idx = 0; nwin = 0; cyc = 0; stall_left = stall_n;
    while (idx < npix && cyc < 300) begin
      pix_in    = W'(base + idx);
      pix_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      win_ready = (win_valid && stall_left > 0) ? 1'b0 : 1'b1;
      #1;
      if (win_valid && !win_ready) begin
        chk("stall_rdy", pix_ready, 0);
        chk("stall_win", win, exp_win(base, 0));
        stall_left--;
      end
      acc = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (nwin < 4 && idx == win_idx[nwin]) begin
          chk("win_valid", win_valid, 1);
          chk("win_data", win, exp_win(base, nwin));
          nwin++;
        end else begin
          chk("no_win", win_valid, 0);
        end
        chk("frame_done", frame_done, (idx == 15) ? 1 : 0);
        idx++;
      end
    end
    pix_valid = 1'b0;
    if (idx < npix) chk("timeout", idx, npix);
    if (npix == 16) chk("win_count", nwin, 4);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; pix_valid = 1'b0; win_ready = 1'b1; pix_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wv", win_valid, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_win", win, '0);
    chk("rst_rdy", pix_ready, 1);

    // Continuous streaming
    run_frame(0, 1'b0, 0, 16);
    idle_tick();

    // Backpressure for 5 cycles on the first window
    run_frame(0, 1'b0, 5, 16);
    idle_tick();

    // Input gaps
    run_frame(0, 1'b1, 0, 16);
    idle_tick();

    // Two frames back to back
    run_frame(0, 1'b0, 0, 16);
    run_frame(100, 1'b0, 0, 16);
    idle_tick();

    // Reset mid-frame
    run_frame(0, 1'b0, 0, 10);
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_in = 32'd77;
    tick();
    chk("midrst_wv", win_valid, 0);
    tick();
    rst = 1'b0;
    pix_valid = 1'b0;
    chk("midrst_win", win, '0);
    chk("midrst_rdy", pix_ready, 1);
    run_frame(0, 1'b0, 0, 16);
    idle_tick();

    // clr blocks the accept of the same cycle and restarts at (0,0)
    run_frame(0, 1'b0, 0, 5);
    clr = 1'b1;
    pix_valid = 1'b1;
    pix_in = 32'd999;
    tick();
    clr = 1'b0;
    pix_valid = 1'b0;
    chk("clr_wv", win_valid, 0);
    chk("clr_fd", frame_done, 0);
    run_frame(0, 1'b0, 0, 16);
    idle_tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
